// File: rtl/fetch_unit_pkg.sv
// Shared CPU definitions: ALU opcodes plus the fetch-stage state encoding and
// instruction-word constants.
package fetch_unit_pkg;

    localparam int unsigned INST_WIDTH = 16;

    // All-zero word decodes as a no-op, so a flushed slot has no side effects.
    localparam logic [INST_WIDTH-1:0] INST_NOP = 16'h0000;

    typedef enum logic [3:0] {
        AluAdd = 4'h0,
        AluSub = 4'h1,
        AluAnd = 4'h2,
        AluOr  = 4'h3,
        AluXor = 4'h4,
        AluShl = 4'h5,
        AluShr = 4'h6,
        AluSar = 4'h7,
        AluSlt = 4'h8,
        AluSltu = 4'h9,
        AluPass = 4'hA
    } alu_op_e;

    typedef enum logic [1:0] {
        FetchIdle    = 2'd0,
        FetchFetch   = 2'd1,
        FetchHold    = 2'd2,
        FetchDiscard = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory over req/ack
// and hands one word at a time to decode over valid/ready.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [INST_WIDTH-1:0] mem_rdata,
    output logic [INST_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    fetch_state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                  inst_valid_q, inst_valid_d;

    assign pc_inc = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FetchIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FetchIdle: begin
                state_d = FetchFetch;
            end
            FetchFetch: begin
                if (redirect) begin
                    // An unacked request cannot be withdrawn, so it must be drained.
                    state_d = mem_ack ? FetchFetch : FetchDiscard;
                end else if (mem_ack) begin
                    state_d = FetchHold;
                end
            end
            FetchHold: begin
                if (redirect || inst_ready) begin
                    state_d = FetchFetch;
                end
            end
            FetchDiscard: begin
                if (mem_ack) begin
                    state_d = FetchFetch;
                end
            end
            default: begin
                state_d = FetchIdle;
            end
        endcase
    end

    always_comb begin
        pc_d         = pc_q;
        mem_addr_d   = mem_addr_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;

        if (redirect) begin
            pc_d         = redirect_pc;
            inst_valid_d = 1'b0;
            inst_d       = INST_NOP;
        end else if (state_q == FetchFetch && mem_ack) begin
            inst_d       = mem_rdata;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
            pc_d         = pc_inc;
        end else if (state_q == FetchHold && inst_ready) begin
            inst_valid_d = 1'b0;
        end

        // Every cycle spent in FETCH presents the current PC; DISCARD keeps the
        // address of the stale request until memory answers it.
        if (state_d == FetchFetch) begin
            mem_addr_d = pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            mem_addr_q   <= RESET_PC;
            inst_q       <= INST_NOP;
            inst_pc_q    <= RESET_PC;
            inst_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            mem_addr_q   <= mem_addr_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    always_comb begin
        mem_req    = (state_q == FetchFetch) || (state_q == FetchDiscard);
        mem_addr   = mem_addr_q;
        inst       = inst_q;
        inst_pc    = inst_pc_q;
        inst_valid = inst_valid_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: a memory responder, a program-order
// reference model and a scoreboard monitor checking every delivered word.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [15:0] redirect_pc;

    logic        req2;
    logic [15:0] addr2;
    logic [15:0] inst2;
    logic [15:0] ipc2;
    logic        valid2;
    logic        ack2;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    // Zero-wait memory, always-ready decode, starting at the top of the address space.
    assign ack2 = req2;
    fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .mem_req(req2), .mem_addr(addr2), .mem_ack(ack2), .mem_rdata(16'hBEEF),
        .inst(inst2), .inst_pc(ipc2), .inst_valid(valid2), .inst_ready(1'b1),
        .redirect(1'b0), .redirect_pc(16'h0000)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        logic [15:0] p;
        p = a * 16'h9E37;
        return p ^ 16'h5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- memory responder + stimulus ----------------
    int mem_cnt = -1;
    int dmax = 0;
    bit stall = 1'b0;
    int p_ready = 100;
    int p_redir = 0;

    task automatic step();
        @(posedge clk);
        #1;
        redirect = 1'b0;
        if (!rst_n) begin
            mem_ack = 1'b0;
            mem_cnt = -1;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            mem_cnt = -1;
        end else if (mem_req) begin
            if (mem_cnt < 0) mem_cnt = int'($urandom_range(dmax, 0));
            if (mem_cnt == 0 && !stall) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_fn(mem_addr);
            end else if (mem_cnt > 0) begin
                mem_cnt--;
            end
        end
        if (!mem_ack) mem_rdata = 16'($urandom);
        inst_ready = int'($urandom_range(99, 0)) < p_ready;
        if (rst_n && int'($urandom_range(99, 0)) < p_redir) begin
            redirect    = 1'b1;
            redirect_pc = 16'($urandom);
        end
    endtask

    task automatic wait_req(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        if (!seen) check(name, 32'(mem_req), 32'd1);
    endtask

    // ---------------- reference model + scoreboard monitor ----------------
    logic [15:0] exp_q[$];
    logic [15:0] next_fetch = 16'h0000;
    logic [15:0] out_addr = 16'h0000;
    bit          out_active = 1'b0;
    bit          out_live = 1'b0;
    bit          exp_req = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            next_fetch = 16'h0000;
            out_active = 1'b0;
            out_live   = 1'b0;
            exp_req    = 1'b0;
        end else begin
            check("valid_vs_model", 32'(inst_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("inst_pc", 32'(inst_pc), 32'(exp_q[0]));
                check("inst_word", 32'(inst), 32'(mem_fn(exp_q[0])));
                check("no_req_while_held", 32'(mem_req), 32'd0);
            end
            if (exp_req) check("req_follows_event", 32'(mem_req), 32'd1);
            exp_req = 1'b0;
            if (mem_req) begin
                if (!out_active) begin
                    check("new_req_addr", 32'(mem_addr), 32'(next_fetch));
                    out_active = 1'b1;
                    out_live   = 1'b1;
                    out_addr   = mem_addr;
                end else begin
                    check("req_addr_stable", 32'(mem_addr), 32'(out_addr));
                end
            end
            if (inst_valid && inst_ready && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                exp_req = 1'b1;
            end
            if (mem_ack && out_active) begin
                if (out_live && !redirect) begin
                    exp_q.push_back(out_addr);
                    next_fetch = out_addr + 16'd1;
                end
                out_active = 1'b0;
            end
            if (redirect) begin
                exp_q.delete();
                next_fetch = redirect_pc;
                out_live   = 1'b0;
                if (!out_active) exp_req = 1'b1;
            end
        end
    end

    // Wrap-around instance: record its first two fetch addresses and delivered PCs.
    logic [15:0] addr2_seen[$];
    logic [15:0] ipc2_seen[$];
    always @(negedge clk) begin
        if (rst_n && req2 && addr2_seen.size() < 2) addr2_seen.push_back(addr2);
        if (rst_n && valid2 && ipc2_seen.size() < 2) begin
            ipc2_seen.push_back(ipc2);
            check("wrap_inst_word", 32'(inst2), 32'h0000BEEF);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

    // ---------------- directed phases and random traffic ----------------
    initial begin
        logic [15:0] old_addr;
        logic [15:0] held_inst;
        logic [15:0] held_pc;
        mem_ack     = 1'b0;
        mem_rdata   = 16'h0000;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        #1 rst_n = 1'b0;
        #11;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0000);
        check("rst_inst", 32'(inst), 32'h0000);
        check("rst_inst_pc", 32'(inst_pc), 32'h0000);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_wrap_mem_addr", 32'(addr2), 32'h0000FFFF);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Zero-wait memory, always-ready decode.
        step();
        check("first_req_after_reset", 32'(mem_req), 32'd1);
        for (int i = 0; i < 30; i++) step();

        // Decode stalls with an instruction held.
        p_ready = 0;
        for (int i = 0; i < 3; i++) step();
        held_inst = inst;
        held_pc   = inst_pc;
        for (int i = 0; i < 5; i++) step();
        check("stall_valid", 32'(inst_valid), 32'd1);
        check("stall_inst", 32'(inst), 32'(held_inst));
        check("stall_inst_pc", 32'(inst_pc), 32'(held_pc));
        check("stall_no_req", 32'(mem_req), 32'd0);
        p_ready = 100;
        for (int i = 0; i < 6; i++) step();

        // Redirect while the memory is slow: stale request must drain first.
        stall = 1'b1;
        step();
        wait_req("redir_wait_req");
        old_addr    = mem_addr;
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        for (int i = 0; i < 3; i++) step();
        check("discard_addr_held", 32'(mem_addr), 32'(old_addr));
        check("discard_req_held", 32'(mem_req), 32'd1);
        stall = 1'b0;
        step();
        check("discard_ack", 32'(mem_ack), 32'd1);
        step();
        check("discard_no_valid", 32'(inst_valid), 32'd0);
        check("redir_target_addr", 32'(mem_addr), 32'h0040);
        for (int i = 0; i < 6; i++) step();

        // Redirect in the same cycle as the acknowledge.
        stall = 1'b1;
        step();
        wait_req("ackredir_wait_req");
        mem_ack     = 1'b1;
        mem_rdata   = mem_fn(mem_addr);
        redirect    = 1'b1;
        redirect_pc = 16'h0080;
        stall       = 1'b0;
        step();
        check("ackredir_no_valid", 32'(inst_valid), 32'd0);
        check("ackredir_req", 32'(mem_req), 32'd1);
        check("ackredir_addr", 32'(mem_addr), 32'h0080);
        for (int i = 0; i < 6; i++) step();

        // Random traffic: variable latency, stalls and redirects.
        dmax    = 3;
        p_ready = 60;
        p_redir = 10;
        for (int i = 0; i < 3000; i++) step();

        // Reset asserted while a stale request is being drained.
        p_redir = 0;
        stall   = 1'b1;
        step();
        wait_req("rst_discard_wait_req");
        redirect    = 1'b1;
        redirect_pc = 16'h1234;
        step();
        check("pre_rst_discard_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_mem_req", 32'(mem_req), 32'd0);
        check("async_rst_mem_addr", 32'(mem_addr), 32'h0000);
        check("async_rst_inst", 32'(inst), 32'h0000);
        check("async_rst_inst_pc", 32'(inst_pc), 32'h0000);
        check("async_rst_inst_valid", 32'(inst_valid), 32'd0);
        stall   = 1'b0;
        dmax    = 0;
        p_ready = 100;
        step();
        step();
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check("restart_req", 32'(mem_req), 32'd1);
        check("restart_addr", 32'(mem_addr), 32'h0000);
        for (int i = 0; i < 20; i++) step();

        if (addr2_seen.size() == 2) begin
            check("wrap_first_addr", 32'(addr2_seen[0]), 32'h0000FFFF);
            check("wrap_second_addr", 32'(addr2_seen[1]), 32'h00000000);
        end else begin
            check("wrap_addr_count", 32'(addr2_seen.size()), 32'd2);
        end
        if (ipc2_seen.size() == 2) begin
            check("wrap_first_pc", 32'(ipc2_seen[0]), 32'h0000FFFF);
            check("wrap_second_pc", 32'(ipc2_seen[1]), 32'h00000000);
        end else begin
            check("wrap_pc_count", 32'(ipc2_seen.size()), 32'd2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
